// File: rtl/bb_monitor.sv
// ---------------------------------------------------------------------------
// bb_monitor
// Watches the transition stream of an upstream tape machine and keeps live
// statistics: step count (saturating), count of nonzero cells (sigma), and
// the lowest/highest head position visited. Once the machine halts, the
// statistics are frozen and streamed out as a 9-byte report over a
// valid/ready byte interface.
//
// Ports
//   CLK_n         in   clock; all state updates on its rising edge
//   rst           in   asynchronous active-high reset
//   step_valid    in   one upstream transition this cycle
//   step_pos      in   [POS_W]  head position of that transition
//   step_old_sym  in   [SYM_W]  symbol read
//   step_new_sym  in   [SYM_W]  symbol written
//   halt_in       in   machine halt flag (level, sticky upstream)
//   steps         out  [STEP_W] transitions counted
//   sigma         out  [POS_W+1] nonzero cell count
//   pos_min       out  [POS_W]  lowest position visited
//   pos_max       out  [POS_W]  highest position visited
//   ovf           out  step counter saturated
//   tx_data       out  [8]  report byte
//   tx_valid      out  tx_data valid
//   tx_ready      in   sink accepts byte
//   done          out  report fully sent
//
// Report byte order: BB, steps[7:0] .. steps[39:32], sigma, pos_min, pos_max
//
// state   | meaning
// --------+--------------------------------------------------------------
// RUN     | counting steps; leaves on halt_in
// HALTED  | single cycle; snapshot statistics into the report register
// DUMP    | streaming report bytes, one per valid/ready handshake
// DONE    | report sent; terminal until reset
// ---------------------------------------------------------------------------
module bb_monitor #(
  parameter int STEP_W = 36,
  parameter int POS_W  = 7,
  parameter int SYM_W  = 3
) (
  input  logic              CLK_n,
  input  logic              rst,
  input  logic              step_valid,
  input  logic [POS_W-1:0]  step_pos,
  input  logic [SYM_W-1:0]  step_old_sym,
  input  logic [SYM_W-1:0]  step_new_sym,
  input  logic              halt_in,
  output logic [STEP_W-1:0] steps,
  output logic [POS_W:0]    sigma,
  output logic [POS_W-1:0]  pos_min,
  output logic [POS_W-1:0]  pos_max,
  output logic              ovf,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done
);

  typedef enum logic [1:0] {RUN, HALTED, DUMP, DONE} state_t;

  localparam logic [STEP_W-1:0] STEP_MAX  = '1;
  localparam logic [POS_W:0]    SIGMA_MAX = {1'b1, {POS_W{1'b0}}};
  localparam logic [3:0]        LAST_IDX  = 4'd8;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [POS_W:0]    sigma_q, sigma_d;
  logic [POS_W-1:0]  pos_min_q, pos_min_d;
  logic [POS_W-1:0]  pos_max_q, pos_max_d;
  logic              ovf_q, ovf_d;
  logic              first_q, first_d;
  logic [39:0]       rpt_steps_q, rpt_steps_d;
  logic [7:0]        rpt_sigma_q, rpt_sigma_d;
  logic [7:0]        rpt_min_q, rpt_min_d;
  logic [7:0]        rpt_max_q, rpt_max_d;
  logic [3:0]        idx_q, idx_d;

  logic              sym_set;
  logic              sym_clr;
  logic [7:0]        cur_byte;

  always_ff @(posedge CLK_n or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      steps_q     <= '0;
      sigma_q     <= '0;
      pos_min_q   <= '0;
      pos_max_q   <= '0;
      ovf_q       <= 1'b0;
      first_q     <= 1'b1;
      rpt_steps_q <= '0;
      rpt_sigma_q <= '0;
      rpt_min_q   <= '0;
      rpt_max_q   <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      steps_q     <= steps_d;
      sigma_q     <= sigma_d;
      pos_min_q   <= pos_min_d;
      pos_max_q   <= pos_max_d;
      ovf_q       <= ovf_d;
      first_q     <= first_d;
      rpt_steps_q <= rpt_steps_d;
      rpt_sigma_q <= rpt_sigma_d;
      rpt_min_q   <= rpt_min_d;
      rpt_max_q   <= rpt_max_d;
      idx_q       <= idx_d;
    end
  end

  assign sym_set = (step_old_sym == '0) && (step_new_sym != '0);
  assign sym_clr = (step_old_sym != '0) && (step_new_sym == '0);

  always_comb begin
    state_d     = state_q;
    steps_d     = steps_q;
    sigma_d     = sigma_q;
    pos_min_d   = pos_min_q;
    pos_max_d   = pos_max_q;
    ovf_d       = ovf_q;
    first_d     = first_q;
    rpt_steps_d = rpt_steps_q;
    rpt_sigma_d = rpt_sigma_q;
    rpt_min_d   = rpt_min_q;
    rpt_max_d   = rpt_max_q;
    idx_d       = idx_q;

    case (state_q)
      RUN: begin
        if (step_valid) begin
          if (steps_q != STEP_MAX) steps_d = steps_q + STEP_W'(1);
          if (steps_d == STEP_MAX) ovf_d = 1'b1;

          // Clamp at both ends so a confused upstream can never wrap sigma.
          if (sym_set && (sigma_q != SIGMA_MAX))
            sigma_d = sigma_q + (POS_W+1)'(1);
          else if (sym_clr && (sigma_q != '0))
            sigma_d = sigma_q - (POS_W+1)'(1);

          // Reset values of min/max are 0, so the first step must load both
          // rather than compare, or pos_min would stick at 0.
          if (first_q) begin
            pos_min_d = step_pos;
            pos_max_d = step_pos;
            first_d   = 1'b0;
          end else begin
            if (step_pos < pos_min_q) pos_min_d = step_pos;
            if (step_pos > pos_max_q) pos_max_d = step_pos;
          end
        end
        if (halt_in) state_d = HALTED;
      end

      HALTED: begin
        rpt_steps_d = 40'(steps_q);
        rpt_sigma_d = 8'(sigma_q);
        rpt_min_d   = 8'(pos_min_q);
        rpt_max_d   = 8'(pos_max_q);
        idx_d       = '0;
        state_d     = DUMP;
      end

      DUMP: begin
        if (tx_ready) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 4'd1;
        end
      end

      DONE: begin
      end

      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      4'd0:    cur_byte = 8'hBB;
      4'd1:    cur_byte = rpt_steps_q[7:0];
      4'd2:    cur_byte = rpt_steps_q[15:8];
      4'd3:    cur_byte = rpt_steps_q[23:16];
      4'd4:    cur_byte = rpt_steps_q[31:24];
      4'd5:    cur_byte = rpt_steps_q[39:32];
      4'd6:    cur_byte = rpt_sigma_q;
      4'd7:    cur_byte = rpt_min_q;
      4'd8:    cur_byte = rpt_max_q;
      default: cur_byte = 8'h00;
    endcase
  end

  // Handshake outputs decode straight from the state flop, so an async
  // reset drops tx_valid without waiting for a clock.
  assign tx_valid = (state_q == DUMP);
  assign tx_data  = tx_valid ? cur_byte : 8'h00;
  assign done     = (state_q == DONE);

  assign steps   = steps_q;
  assign sigma   = sigma_q;
  assign pos_min = pos_min_q;
  assign pos_max = pos_max_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bb_monitor.sv
module tb_bb_monitor;

  logic        CLK_n;
  logic        rst;
  logic        step_valid;
  logic [6:0]  step_pos;
  logic [2:0]  step_old_sym;
  logic [2:0]  step_new_sym;
  logic        halt_in;
  logic        tx_ready;

  logic [35:0] steps_m;
  logic [7:0]  sigma_m;
  logic [6:0]  pos_min_m, pos_max_m;
  logic        ovf_m, tx_valid_m, done_m;
  logic [7:0]  tx_data_m;

  logic [3:0]  steps_s;
  logic [7:0]  sigma_s;
  logic [6:0]  pos_min_s, pos_max_s;
  logic        ovf_s, tx_valid_s, done_s;
  logic [7:0]  tx_data_s;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] got_m [0:15];
  logic [7:0] got_s [0:15];
  int         n_hs;

  bb_monitor dut_m (
    .CLK_n(CLK_n), .rst(rst), .step_valid(step_valid), .step_pos(step_pos),
    .step_old_sym(step_old_sym), .step_new_sym(step_new_sym), .halt_in(halt_in),
    .steps(steps_m), .sigma(sigma_m), .pos_min(pos_min_m), .pos_max(pos_max_m),
    .ovf(ovf_m), .tx_data(tx_data_m), .tx_valid(tx_valid_m), .tx_ready(tx_ready),
    .done(done_m)
  );

  bb_monitor #(.STEP_W(4)) dut_s (
    .CLK_n(CLK_n), .rst(rst), .step_valid(step_valid), .step_pos(step_pos),
    .step_old_sym(step_old_sym), .step_new_sym(step_new_sym), .halt_in(halt_in),
    .steps(steps_s), .sigma(sigma_s), .pos_min(pos_min_s), .pos_max(pos_max_s),
    .ovf(ovf_s), .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_ready(tx_ready),
    .done(done_s)
  );

  initial begin
    CLK_n = 1'b0;
    forever #5 CLK_n = ~CLK_n;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    halt_in = 1'b0;
    step_valid = 1'b0;
    tx_ready = 1'b0;
    @(posedge CLK_n); #1;
    rst = 1'b0;
  endtask

  task automatic do_step(input logic [6:0] p, input logic [2:0] o, input logic [2:0] n);
    step_valid = 1'b1;
    step_pos = p;
    step_old_sym = o;
    step_new_sym = n;
    @(posedge CLK_n); #1;
    step_valid = 1'b0;
  endtask

  // Runs the sink side until done (stop_after=0) or a given handshake count.
  // toggle selects the ready pattern 1,0,0,1 repeating over DUMP cycles.
  task automatic collect(input int stop_after, input bit toggle);
    bit hold;
    logic [7:0] held;
    int dc;
    n_hs = 0;
    hold = 1'b0;
    held = 8'h00;
    dc = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done_m || (stop_after > 0 && n_hs == stop_after)) break;
      tx_ready = toggle ? ((dc % 4 == 0) || (dc % 4 == 3)) : 1'b1;
      if (tx_valid_m) dc++;
      if (hold) begin
        chk("hold_data", tx_data_m, held);
        chk("hold_valid", tx_valid_m, 1);
      end
      hold = tx_valid_m && !tx_ready;
      held = tx_data_m;
      if (tx_valid_m && tx_ready) begin
        if (n_hs < 16) begin
          got_m[n_hs] = tx_data_m;
          got_s[n_hs] = tx_data_s;
        end
        n_hs++;
      end
      @(posedge CLK_n); #1;
    end
    if (stop_after > 0) chk("hs_count_partial", n_hs, stop_after);
    else begin
      chk("dump_done", done_m, 1);
      chk("hs_count", n_hs, 9);
    end
  endtask

  task automatic chk_report(input string tag, input logic [71:0] exp_v);
    for (int i = 0; i < 9; i++) chk(tag, got_m[i], exp_v[71-8*i -: 8]);
  endtask

  initial begin
    rst = 1'b1;
    step_valid = 1'b0;
    step_pos = '0;
    step_old_sym = '0;
    step_new_sym = '0;
    halt_in = 1'b0;
    tx_ready = 1'b0;
    #2;
    chk("rst_steps", steps_m, 0);
    chk("rst_sigma", sigma_m, 0);
    chk("rst_min", pos_min_m, 0);
    chk("rst_max", pos_max_m, 0);
    chk("rst_ovf", ovf_m, 0);
    chk("rst_tx_valid", tx_valid_m, 0);
    chk("rst_tx_data", tx_data_m, 0);
    chk("rst_done", done_m, 0);
    @(posedge CLK_n); #1;
    rst = 1'b0;

    // Basic three-step run
    do_step(7'd0, 3'd0, 3'd1);
    chk("a1_steps", steps_m, 1);
    chk("a1_sigma", sigma_m, 1);
    do_step(7'd1, 3'd0, 3'd2);
    chk("a2_sigma", sigma_m, 2);
    do_step(7'd0, 3'd1, 3'd0);
    chk("a_steps", steps_m, 3);
    chk("a_sigma", sigma_m, 1);
    chk("a_min", pos_min_m, 0);
    chk("a_max", pos_max_m, 1);
    halt_in = 1'b1;
    collect(0, 1'b0);
    chk_report("a_report", 72'hBB_03_00_00_00_00_01_00_01);
    chk("a_done", done_m, 1);
    chk("a_tx_valid_after", tx_valid_m, 0);
    halt_in = 1'b0;
    repeat (3) @(posedge CLK_n);
    #1;
    chk("a_done_sticky", done_m, 1);
    chk("a_tx_valid_sticky", tx_valid_m, 0);

    // Min/max tracking, sigma floor, hold without steps, ready toggling
    do_reset();
    chk("b_rst_steps", steps_m, 0);
    do_step(7'd5, 3'd1, 3'd0);
    chk("b_sigma_floor", sigma_m, 0);
    chk("b_first_min", pos_min_m, 5);
    chk("b_first_max", pos_max_m, 5);
    do_step(7'd2, 3'd0, 3'd0);
    do_step(7'd9, 3'd0, 3'd0);
    do_step(7'd9, 3'd0, 3'd0);
    step_pos = 7'd0;
    repeat (2) @(posedge CLK_n);
    #1;
    chk("b_hold_steps", steps_m, 4);
    chk("b_min", pos_min_m, 2);
    chk("b_max", pos_max_m, 9);
    halt_in = 1'b1;
    collect(0, 1'b1);
    chk_report("b_report", 72'hBB_04_00_00_00_00_00_02_09);

    // Saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 14; i++) do_step(7'(i), 3'd0, 3'd0);
    chk("c_s14_steps", steps_s, 14);
    chk("c_s14_ovf", ovf_s, 0);
    do_step(7'd14, 3'd0, 3'd0);
    chk("c_s15_steps", steps_s, 15);
    chk("c_s15_ovf", ovf_s, 1);
    for (int i = 15; i < 20; i++) do_step(7'(i), 3'd0, 3'd0);
    chk("c_s_steps", steps_s, 15);
    chk("c_s_ovf", ovf_s, 1);
    chk("c_m_steps", steps_m, 20);
    chk("c_m_ovf", ovf_m, 0);
    halt_in = 1'b1;
    collect(0, 1'b0);
    chk_report("c_report", 72'hBB_14_00_00_00_00_00_00_13);
    chk("c_s_byte0", got_s[0], 8'hBB);
    chk("c_s_byte1", got_s[1], 8'h0F);

    // Step coincident with halt is counted; later steps ignored
    do_reset();
    for (int i = 0; i < 6; i++) do_step(7'd1, 3'd0, 3'd1);
    step_valid = 1'b1;
    halt_in = 1'b1;
    @(posedge CLK_n); #1;
    collect(0, 1'b0);
    step_valid = 1'b0;
    chk_report("d_report", 72'hBB_07_00_00_00_00_07_01_01);
    chk("d_steps_frozen", steps_m, 7);
    chk("d_sigma_frozen", sigma_m, 7);

    // Reset in the middle of the dump
    do_reset();
    do_step(7'd4, 3'd0, 3'd3);
    do_step(7'd6, 3'd0, 3'd3);
    halt_in = 1'b1;
    collect(4, 1'b0);
    chk("e_b0", got_m[0], 8'hBB);
    chk("e_b1", got_m[1], 8'h02);
    chk("e_b3", got_m[3], 8'h00);
    #2;
    rst = 1'b1;
    halt_in = 1'b0;
    #1;
    chk("e_async_tx_valid", tx_valid_m, 0);
    chk("e_async_tx_data", tx_data_m, 0);
    chk("e_async_steps", steps_m, 0);
    chk("e_async_sigma", sigma_m, 0);
    chk("e_async_min", pos_min_m, 0);
    chk("e_async_max", pos_max_m, 4'd0);
    @(posedge CLK_n); #1;
    chk("e_rst_tx_valid", tx_valid_m, 0);
    chk("e_rst_done", done_m, 0);
    rst = 1'b0;
    @(posedge CLK_n); #1;
    chk("e_idle_tx_valid", tx_valid_m, 0);
    do_step(7'd3, 3'd0, 3'd5);
    halt_in = 1'b1;
    collect(0, 1'b0);
    chk_report("e_report", 72'hBB_01_00_00_00_00_01_03_03);
    halt_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bb_monitor.md
BB_MONITOR -- requirements
Module: bb_monitor

Interface
REQ-001 SHALL have parameters: STEP_W, default 36, step-counter width; POS_W, default 7, tape-position width; SYM_W, default 3, tape-symbol width.
REQ-002 SHALL have ports: CLK_n  in  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: step_valid  in  1  the upstream machine performed one transition this cycle.
REQ-005 SHALL have ports: step_pos  in  POS_W  head position of that transition.
REQ-006 SHALL have ports: step_old_sym  in  SYM_W  symbol read.
REQ-007 SHALL have ports: step_new_sym  in  SYM_W  symbol written.
REQ-008 SHALL have ports: halt_in  in  1  machine halt flag, level, sticky upstream.
REQ-009 SHALL have ports: steps  out  STEP_W  transitions counted.
REQ-010 SHALL have ports: sigma  out  POS_W+1  count of nonzero cells.
REQ-011 SHALL have ports: pos_min  out  POS_W  lowest position visited.
REQ-012 SHALL have ports: pos_max  out  POS_W  highest position visited.
REQ-013 SHALL have ports: ovf  out  1  step counter saturated.
REQ-014 SHALL have ports: tx_data  out  8  report byte.
REQ-015 SHALL have ports: tx_valid  out  1  tx_data valid.
REQ-016 SHALL have ports: tx_ready  in  1  sink accepts byte.
REQ-017 SHALL have ports: done  out  1  report fully sent.

Function
REQ-018 SHALL implement FSM states RUN, HALTED, DUMP, DONE; RUN is entered on reset.
REQ-019 In RUN, each cycle with step_valid=1 SHALL increment steps by 1, saturating at all-ones; on reaching all-ones, ovf SHALL be set and remain set until reset.
REQ-020 In RUN with step_valid=1, sigma SHALL increment when old=0 and new!=0, decrement when old!=0 and new=0, and hold otherwise; it SHALL never wrap below 0 or above 2^POS_W.
REQ-021 In RUN with step_valid=1, pos_min/pos_max SHALL be updated with unsigned compare against step_pos; the first step after reset SHALL load both with step_pos.
REQ-022 SHALL leave steps, sigma, pos_min, and pos_max unchanged on cycles without step_valid.
REQ-023 When halt_in=1 is sampled in RUN, the FSM SHALL go to HALTED on the next edge; a step_valid in that same cycle SHALL still be counted.
REQ-024 SHALL ignore step_valid in HALTED, DUMP, and DONE.
REQ-025 HALTED SHALL last exactly one cycle and freeze the statistics into a report register, then go to DUMP.
REQ-026 SHALL form the report as 9 bytes in this order: 0xBB header; steps as 5 bytes little-endian, zero-padded to 40 bits; sigma as 1 byte; pos_min as 1 byte, zero-extended; pos_max as 1 byte, zero-extended.
REQ-027 In DUMP, tx_valid SHALL be 1 and tx_data SHALL hold the current byte; a byte SHALL advance only on a cycle with tx_valid and tx_ready both high.
REQ-028 While tx_ready=0, tx_data and tx_valid SHALL stay stable.
REQ-029 On the handshake of byte 9, the FSM SHALL enter DONE, tx_valid SHALL be 0 next cycle, and done SHALL be 1 from the next cycle.
REQ-030 DONE SHALL be terminal until reset; halt_in going low SHALL have no effect after RUN.
REQ-031 Live outputs steps, sigma, pos_min, pos_max, and ovf SHALL be registered and reflect updates one cycle after the step.
REQ-032 Throughput in RUN SHALL be one step per cycle with no back-pressure.

Reset
REQ-033 rst SHALL take effect asynchronously and force FSM=RUN, steps=0, sigma=0, pos_min=0, pos_max=0, ovf=0, tx_valid=0, tx_data=0, done=0, and byte index=0.
REQ-034 Reset asserted mid-DUMP SHALL abort the report immediately, with no further bytes sent, and release into RUN.

Verification
REQ-035 Bench SHALL drive 3 steps (pos 0/old 0/new 1, pos 1/old 0/new 2, pos 0/old 1/new 0), then halt_in=1 with tx_ready=1 -> steps=3, sigma=1, pos_min=0, pos_max=1; bytes BB 03 00 00 00 00 01 00 01; done=1.
REQ-036 Bench SHALL preload the counter via STEP_W=4 and apply 20 steps -> steps=15, ovf=1; reported byte1 0F.
REQ-037 Bench SHALL toggle tx_ready 1-0-0-1 during DUMP -> each byte held stable while ready=0, exactly 9 handshakes total, no duplicates.
REQ-038 Bench SHALL assert step_valid and halt_in in the same cycle after 6 prior steps -> steps=7 in report.
REQ-039 Bench SHALL assert rst after byte 4 handshakes -> tx_valid=0 asynchronously, all stats 0, and a new run completes correctly.
REQ-040 Bench SHALL apply steps with pos 5, 2, 9, 9 -> pos_min=2, pos_max=9.
